acq_search_ctrl: RTL
====================

ACQ_SEARCH_CTRL -- requirements
Module: acq_search_ctrl

Interface
REQ-001 clk  in  1  system clock; all logic on posedge.
REQ-002 rstn  in  1  reset, synchronous, active-low.
REQ-003 start  in  1  one-cycle pulse; begins a search; ignored while busy.
REQ-004 abort  in  1  level/pulse; terminates any search.
REQ-005 prn_sel  in  10  G2 initial state for the searched satellite.
REQ-006 step  in  11  half-chips per bin; 0 treated as 1; sampled at start.
REQ-007 dwell  in  4  samples per bin minus 1 (1..16); sampled at start.
REQ-008 threshold  in  36  detection threshold; sampled at start.
REQ-009 dump_enable  in  1  C/A code-cycle pulse from code generator.
REQ-010 energy  in  32  unsigned I²+Q² of one code cycle; qualified by energy_valid.
REQ-011 energy_valid  in  1  one-cycle pulse per completed code-cycle energy.
REQ-012 prn_key  out  10  key to code generator; registered copy of prn_sel.
REQ-013 prn_key_enable  out  1  one-cycle load pulse to code generator.
REQ-014 code_slew  out  11  half-chip slew to code generator.
REQ-015 slew_enable  out  1  one-cycle slew write pulse.
REQ-016 busy  out  1  high from cycle after accepted start until done or abort.
REQ-017 done  out  1  one-cycle pulse at search completion (not on abort).
REQ-018 found  out  1  valid with done; held until next accepted start.
REQ-019 best_phase  out  12  half-chip offset (0..2045) of reported bin; held.
REQ-020 best_energy  out  36  summed energy of reported bin; held.

Function
REQ-021 States: IDLE, LOAD, SLEW, SETTLE, MEAS, CHECK, DONE.
REQ-022 IDLE->LOAD on start; latch prn_sel, step, dwell, threshold; clear phase, max, found.
REQ-023 LOAD: prn_key_enable=1 for exactly one cycle, prn_key valid same cycle; ->SETTLE.
REQ-024 SLEW: code_slew=step (held until next SLEW), slew_enable=1 for one cycle; ->SETTLE.
REQ-025 SETTLE: count 2 dump_enable pulses, then ->MEAS; energy_valid in SETTLE discarded.
REQ-026 MEAS: add energy, zero-extended, into 36-bit sum on each energy_valid; after dwell+1 samples ->CHECK.
REQ-027 CHECK (one cycle): if sum > threshold (strict): best_phase=phase, best_energy=sum, found=1, ->DONE.
REQ-028 CHECK else: if sum > current max (strict; ties keep earlier bin) record phase/sum as best.
REQ-029 CHECK else: if phase + step >= 2046 ->DONE with found=0; else phase += step (12-bit, no wrap), ->SLEW.
REQ-030 DONE: done=1 one cycle, busy=0 same cycle, ->IDLE.
REQ-031 Bin count = ceil(2046/step); step=1 gives 2046 bins, step>=2046 gives 1 bin.
REQ-032 abort in any non-IDLE state: ->IDLE next cycle, busy=0, done not pulsed, no further prn_key_enable/slew_enable; best_* and found hold prior values.
REQ-033 abort and start same cycle in IDLE: abort wins, start ignored.
REQ-034 dump_enable and energy_valid same cycle: both processed in that cycle.
REQ-035 Sum saturates at 2^36-1 (cannot occur at 16x32b; required for safety).
REQ-036 prn_key_enable and slew_enable never asserted in the same cycle.

Reset
REQ-037 rstn=0 at posedge: state=IDLE; all outputs 0, including prn_key, code_slew, best_phase, best_energy.
REQ-038 Reset mid-search behaves as abort plus clearing held results; first start after reset accepted.

Structure
REQ-039 Shared package acq_pkg: state enumeration, CA_HALF_CHIPS=2046, SETTLE_DUMPS=2, widths 10/11/12/36.
REQ-040 One sub-module acq_accum: 36-bit saturating dwell accumulator with clear, add and sample count.
REQ-041 Implementation is a single FSM plus counters; no handshake with code generator beyond listed pulses.

Verification
REQ-042 start, prn_sel=0x3EC, step=2047, dwell=0, energy=10 each, threshold=100 -> one prn_key_enable (prn_key=0x3EC), no slew_enable, done, found=0, best_phase=0, best_energy=10.
REQ-043 step=2, dwell=3, energy 1000 only for bin phase=20, else 5, threshold=3000 -> 10 slew_enables (code_slew=2), done, found=1, best_phase=20, best_energy=4000.
REQ-044 step=1023, threshold=2^36-1, bin energies 7 then 7 -> 2 bins, found=0, best_phase=0 (tie keeps earlier).
REQ-045 energy_valid pulses during SETTLE with energy=0xFFFFFFFF -> excluded; best_energy equals MEAS samples only.
REQ-046 abort in MEAS of bin 3 -> busy=0 next cycle, no done, no further slew_enable; new start re-runs from phase 0.
REQ-047 rstn low during SLEW -> all outputs 0 next cycle; start after release runs normally.

Source files
------------

// File: rtl/acq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// acq_pkg : shared types and constants for the acquisition search
// Rev 1.0
// ------------------------------------------------------------------
package acq_pkg;
   localparam int CA_HALF_CHIPS = 2046;
   localparam int SETTLE_DUMPS  = 2;
   localparam int KEY_W         = 10;
   localparam int SLEW_W        = 11;
   localparam int PHASE_W       = 12;
   localparam int SUM_W         = 36;
   localparam int ENERGY_W      = 32;
   localparam int DWELL_W       = 4;
   localparam int CNT_W         = 5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SLEW   = 3'd2,
      S_SETTLE = 3'd3,
      S_MEAS   = 3'd4,
      S_CHECK  = 3'd5,
      S_DONE   = 3'd6
   } acq_state_e;
endpackage
`default_nettype wire

// File: rtl/acq_accum.sv
`default_nettype none
// ------------------------------------------------------------------
// acq_accum : saturating per-bin energy accumulator with sample count
// Rev 1.0
// ------------------------------------------------------------------
module acq_accum
   import acq_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   input  logic                clr,
   input  logic                add,
   input  logic [ENERGY_W-1:0] din,
   output logic [SUM_W-1:0]    sum,
   output logic [CNT_W-1:0]    count
);
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SUM_W:0]   sum_ext;

   always_comb begin
      sum_ext = {1'b0, sum_q} + {{(SUM_W + 1 - ENERGY_W){1'b0}}, din};
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      if (clr) begin
         sum_d = '0;
         cnt_d = '0;
      end else if (add) begin
         // carry out of the 36-bit sum pins the result at full scale
         sum_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sum_q <= '0;
         cnt_q <= '0;
      end else begin
         sum_q <= sum_d;
         cnt_q <= cnt_d;
      end
   end

   assign sum   = sum_q;
   assign count = cnt_q;
endmodule
`default_nettype wire

// File: rtl/acq_search_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// acq_search_ctrl : serial code-phase search sequencer for one PRN
// Rev 1.0
// ------------------------------------------------------------------
module acq_search_ctrl
   import acq_pkg::*;
(
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic                abort,
   input  logic [KEY_W-1:0]    prn_sel,
   input  logic [SLEW_W-1:0]   step,
   input  logic [DWELL_W-1:0]  dwell,
   input  logic [SUM_W-1:0]    threshold,
   input  logic                dump_enable,
   input  logic [ENERGY_W-1:0] energy,
   input  logic                energy_valid,
   output logic [KEY_W-1:0]    prn_key,
   output logic                prn_key_enable,
   output logic [SLEW_W-1:0]   code_slew,
   output logic                slew_enable,
   output logic                busy,
   output logic                done,
   output logic                found,
   output logic [PHASE_W-1:0]  best_phase,
   output logic [SUM_W-1:0]    best_energy
);
   acq_state_e           state_q, state_d;
   logic [KEY_W-1:0]     key_q, key_d;
   logic [SLEW_W-1:0]    step_q, step_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [SUM_W-1:0]     thr_q, thr_d;
   logic [PHASE_W-1:0]   phase_q, phase_d;
   logic [PHASE_W-1:0]   best_phase_q, best_phase_d;
   logic [SUM_W-1:0]     best_energy_q, best_energy_d;
   logic                 found_q, found_d;
   logic [SLEW_W-1:0]    code_slew_q, code_slew_d;
   logic [1:0]           settle_q, settle_d;
   logic [PHASE_W:0]     next_phase;
   logic                 acc_clr, acc_add;
   logic [SUM_W-1:0]     acc_sum;
   logic [CNT_W-1:0]     acc_count;

   acq_accum u_accum (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (acc_clr),
      .add   (acc_add),
      .din   (energy),
      .sum   (acc_sum),
      .count (acc_count)
   );

   always_comb begin
      state_d        = state_q;
      key_d          = key_q;
      step_d         = step_q;
      dwell_d        = dwell_q;
      thr_d          = thr_q;
      phase_d        = phase_q;
      best_phase_d   = best_phase_q;
      best_energy_d  = best_energy_q;
      found_d        = found_q;
      code_slew_d    = code_slew_q;
      settle_d       = settle_q;
      acc_clr        = 1'b0;
      acc_add        = 1'b0;
      prn_key_enable = 1'b0;
      slew_enable    = 1'b0;
      done           = 1'b0;
      next_phase     = {1'b0, phase_q} + {{(PHASE_W + 1 - SLEW_W){1'b0}}, step_q};

      // abort overrides everything, including a simultaneous start
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d       = S_LOAD;
                  key_d         = prn_sel;
                  step_d        = (step == '0) ? SLEW_W'(1) : step;
                  dwell_d       = dwell;
                  thr_d         = threshold;
                  phase_d       = '0;
                  best_phase_d  = '0;
                  best_energy_d = '0;
                  found_d       = 1'b0;
               end
            end
            S_LOAD: begin
               prn_key_enable = 1'b1;
               acc_clr        = 1'b1;
               settle_d       = '0;
               state_d        = S_SETTLE;
            end
            S_SLEW: begin
               slew_enable = 1'b1;
               acc_clr     = 1'b1;
               settle_d    = '0;
               state_d     = S_SETTLE;
            end
            S_SETTLE: begin
               if (dump_enable) begin
                  if (settle_q == 2'(SETTLE_DUMPS - 1)) state_d = S_MEAS;
                  else settle_d = settle_q + 1'b1;
               end
            end
            S_MEAS: begin
               if (energy_valid) begin
                  acc_add = 1'b1;
                  if (acc_count == {1'b0, dwell_q}) state_d = S_CHECK;
               end
            end
            S_CHECK: begin
               if (acc_sum > thr_q) begin
                  best_phase_d  = phase_q;
                  best_energy_d = acc_sum;
                  found_d       = 1'b1;
                  state_d       = S_DONE;
               end else begin
                  if (acc_sum > best_energy_q) begin
                     best_phase_d  = phase_q;
                     best_energy_d = acc_sum;
                  end
                  if (next_phase >= (PHASE_W + 1)'(CA_HALF_CHIPS)) begin
                     state_d = S_DONE;
                  end else begin
                     phase_d     = next_phase[PHASE_W-1:0];
                     code_slew_d = step_q;
                     state_d     = S_SLEW;
                  end
               end
            end
            S_DONE: begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         key_q         <= '0;
         step_q        <= '0;
         dwell_q       <= '0;
         thr_q         <= '0;
         phase_q       <= '0;
         best_phase_q  <= '0;
         best_energy_q <= '0;
         found_q       <= 1'b0;
         code_slew_q   <= '0;
         settle_q      <= '0;
      end else begin
         state_q       <= state_d;
         key_q         <= key_d;
         step_q        <= step_d;
         dwell_q       <= dwell_d;
         thr_q         <= thr_d;
         phase_q       <= phase_d;
         best_phase_q  <= best_phase_d;
         best_energy_q <= best_energy_d;
         found_q       <= found_d;
         code_slew_q   <= code_slew_d;
         settle_q      <= settle_d;
      end
   end

   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign prn_key     = key_q;
   assign code_slew   = code_slew_q;
   assign found       = found_q;
   assign best_phase  = best_phase_q;
   assign best_energy = best_energy_q;
endmodule
`default_nettype wire
